decode_regread: RTL and testbench

- Stage directly downstream of the fetch stage in the 16-bit multi-cycle CPU.
- Captures the instruction word when fetch loads IR (IRWrite pulse), splits it into fields and builds the immediate.
- Reads an 8x16 register file and presents latched operands A/B, Imm, Rd and Opcode to the execute/ALU datapath under a valid/ack handshake.
- Owns the register file write port used by writeback.

---
 rtl/decode_regread_pkg.sv | 46 ++++
 rtl/decode_regread_if.sv | 30 +++
 rtl/decode_regread_reg_file.sv | 38 +++
 rtl/decode_regread.sv | 107 ++++++++++
 tb/tb_decode_regread.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/decode_regread_pkg.sv
// Shared CPU decode definitions: widths, instruction field positions,
// immediate class encodings and the decode stage state encoding.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int ADDR_W = 3;
   localparam int OPC_W  = 5;

   // Immediate class, taken from the top two opcode bits
   localparam logic [1:0] CLS_R = 2'b00;
   localparam logic [1:0] CLS_I = 2'b01;
   localparam logic [1:0] CLS_J = 2'b10;
   localparam logic [1:0] CLS_U = 2'b11;

   // Instruction field bit positions
   localparam int OPC_LSB   = 0;
   localparam int OPC_MSB   = 4;
   localparam int RD_LSB    = 5;
   localparam int RD_MSB    = 7;
   localparam int RS1_LSB   = 8;
   localparam int RS1_MSB   = 10;
   localparam int RS2_LSB   = 11;
   localparam int RS2_MSB   = 13;
   localparam int CLS_LSB   = 3;
   localparam int CLS_MSB   = 4;
   localparam int IMM_I_LSB = 11;
   localparam int IMM_J_LSB = 5;
   localparam int IMM_U_LSB = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_VALID  = 2'd2
   } dec_state_e;

   // Everything the stage presents to execute, latched together in DECODE
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] imm;
      logic [ADDR_W-1:0] rd;
      logic [OPC_W-1:0]  opc;
   } dec_out_t;

endpackage

// File: rtl/decode_regread_if.sv
// Fetch/execute/writeback facing signals of the decode stage.
// master = the surrounding pipeline, slave = the decode stage.
interface decode_regread_if;
   import cpu_pkg::*;

   logic [DATA_W-1:0] IRIn;
   logic              IRValid;
   logic              Busy;
   logic              DecValid;
   logic              DecAck;
   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [DATA_W-1:0] Imm;
   logic [ADDR_W-1:0] Rd;
   logic [OPC_W-1:0]  Opcode;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteAddr;
   logic [DATA_W-1:0] WriteData;

   modport master (
      output IRIn, IRValid, DecAck, RegWrite, WriteAddr, WriteData,
      input  Busy, DecValid, A, B, Imm, Rd, Opcode
   );

   modport slave (
      input  IRIn, IRValid, DecAck, RegWrite, WriteAddr, WriteData,
      output Busy, DecValid, A, B, Imm, Rd, Opcode
   );

endinterface

// File: rtl/decode_regread_reg_file.sv
// 8x16 register file: one synchronous write port, two combinational
// read ports, register 0 reads as zero, whole array cleared on reset.
module reg_file_8x16
   import cpu_pkg::*;
#(
   parameter int DW    = DATA_W,
   parameter int NR    = NREGS,
   parameter int AW    = ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   output logic [DW-1:0] rdata1,
   output logic [DW-1:0] rdata2
);

   logic [DW-1:0] mem [NR];

   // Write port; reset has priority so a write in the reset cycle is lost
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) mem[i] <= '0;
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   // Read ports; x0 is forced to zero regardless of array contents
   always_comb begin
      rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
      rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
   end

endmodule

// File: rtl/decode_regread.sv
// Decode / register-read stage: captures IR from fetch, extracts fields,
// builds the immediate, reads operands (with writeback bypass) and hands
// the latched result to execute under a DecValid/DecAck handshake.
module decode_regread
   import cpu_pkg::*;
(
   input  logic             CLK,
   input  logic             RST,
   decode_regread_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = S_IDLE;
   localparam logic [1:0] ST_DECODE = S_DECODE;
   localparam logic [1:0] ST_VALID  = S_VALID;

   logic [1:0]        state, state_nx;
   logic [DATA_W-1:0] ir;
   logic              accept;
   logic [ADDR_W-1:0] rs1, rs2;
   logic [DATA_W-1:0] rd1, rd2;
   logic [DATA_W-1:0] imm;
   logic              wb_hit;
   dec_out_t          dec_nx, dec_q;

   assign rs1 = ir[RS1_MSB:RS1_LSB];
   assign rs2 = ir[RS2_MSB:RS2_LSB];

   // A new word is taken from IDLE, or from VALID when the consumer drains
   // the current result in the same cycle (back-to-back, no bubble)
   assign accept = bus.IRValid &&
                   ((state == ST_IDLE) || ((state == ST_VALID) && bus.DecAck));

   // Next-state logic; DECODE always lasts exactly one cycle
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (bus.IRValid) state_nx = ST_DECODE;
         ST_DECODE: state_nx = ST_VALID;
         ST_VALID:  if (bus.DecAck) state_nx = bus.IRValid ? ST_DECODE : ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Instruction register; words offered while busy are dropped
   always_ff @(posedge CLK) begin
      if (RST)         ir <= '0;
      else if (accept) ir <= bus.IRIn;
   end

   reg_file_8x16 u_rf (
      .clk    (CLK),
      .rst    (RST),
      .we     (bus.RegWrite),
      .waddr  (bus.WriteAddr),
      .wdata  (bus.WriteData),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rd1),
      .rdata2 (rd2)
   );

   // Immediate by class: R none, I/J sign-extended, U zero-extended
   always_comb begin
      imm = '0;
      case (ir[CLS_MSB:CLS_LSB])
         CLS_R: imm = '0;
         CLS_I: imm = {{IMM_I_LSB{ir[DATA_W-1]}}, ir[DATA_W-1:IMM_I_LSB]};
         CLS_J: imm = {{IMM_J_LSB{ir[DATA_W-1]}}, ir[DATA_W-1:IMM_J_LSB]};
         CLS_U: imm = {{IMM_U_LSB{1'b0}}, ir[DATA_W-1:IMM_U_LSB]};
         default: imm = '0;
      endcase
   end

   // Operand selection; a writeback landing in the DECODE cycle would be
   // missed by the array read, so forward it directly
   assign wb_hit = bus.RegWrite && (bus.WriteAddr != '0);

   always_comb begin
      dec_nx     = '0;
      dec_nx.a   = (wb_hit && (bus.WriteAddr == rs1)) ? bus.WriteData : rd1;
      dec_nx.b   = (wb_hit && (bus.WriteAddr == rs2)) ? bus.WriteData : rd2;
      dec_nx.imm = imm;
      dec_nx.rd  = ir[RD_MSB:RD_LSB];
      dec_nx.opc = ir[OPC_MSB:OPC_LSB];
   end

   // Output latch: loaded only in DECODE, held stable through VALID
   always_ff @(posedge CLK) begin
      if (RST)                     dec_q <= '0;
      else if (state == ST_DECODE) dec_q <= dec_nx;
   end

   assign bus.A        = dec_q.a;
   assign bus.B        = dec_q.b;
   assign bus.Imm      = dec_q.imm;
   assign bus.Rd       = dec_q.rd;
   assign bus.Opcode   = dec_q.opc;
   assign bus.DecValid = (state == ST_VALID);
   assign bus.Busy     = (state == ST_DECODE) || ((state == ST_VALID) && !bus.DecAck);

endmodule

// File: tb/tb_decode_regread.sv
// Bench for decode_regread: a reference register model produces the
// expected operands when each word is issued; a monitor pops and compares
// them when DecValid rises, including the two-cycle latency.
module tb_decode_regread;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct {
      logic [15:0] a, b, imm;
      logic [2:0]  rd;
      logic [4:0]  opc;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model [8];

   decode_regread_if bus ();

   decode_regread dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_imm(input logic [15:0] w);
      logic [15:0] r;
      case (w[4:3])
         2'b00:   r = 16'h0000;
         2'b01:   r = {{11{w[15]}}, w[15:11]};
         2'b10:   r = {{5{w[15]}}, w[15:5]};
         default: r = {8'h00, w[15:8]};
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.RegWrite = 1'b1; bus.WriteAddr = a; bus.WriteData = d;
      if (a != 3'd0) model[a] = d;
      tick();
      bus.RegWrite = 1'b0;
   endtask

   // Offer a word (from IDLE, or from VALID with DecAck when b2b), optionally
   // writing back during the DECODE cycle; returns with the stage in VALID.
   task automatic issue(input logic [15:0] w, input bit b2b, input bit bw,
                        input logic [2:0] wa, input logic [15:0] wd);
      exp_t e;
      bus.IRIn = w; bus.IRValid = 1'b1; bus.DecAck = b2b;
      #1;
      check("busy_at_accept", {31'd0, bus.Busy}, 32'd0);
      e.cyc = cyc;
      tick();
      bus.IRValid = 1'b0; bus.DecAck = 1'b0;
      check("busy_decode", {31'd0, bus.Busy}, 32'd1);
      check("valid_decode", {31'd0, bus.DecValid}, 32'd0);
      if (bw) begin
         bus.RegWrite = 1'b1; bus.WriteAddr = wa; bus.WriteData = wd;
         if (wa != 3'd0) model[wa] = wd;
      end
      e.a   = model[w[10:8]];
      e.b   = model[w[13:11]];
      e.imm = ref_imm(w);
      e.rd  = w[7:5];
      e.opc = w[4:0];
      sb.push_back(e);
      tick();
      bus.RegWrite = 1'b0;
   endtask

   task automatic ack();
      bus.DecAck = 1'b1;
      tick();
      bus.DecAck = 1'b0;
      check("idle_after_ack", {31'd0, bus.DecValid}, 32'd0);
   endtask

   // Scoreboard monitor: each rising DecValid consumes one expectation
   initial begin
      logic prev_v;
      exp_t e;
      prev_v = 1'b0;
      forever begin
         @(negedge CLK);
         if (bus.DecValid && !prev_v) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("latency", cyc - e.cyc, 32'd2);
               check("A", {16'd0, bus.A}, {16'd0, e.a});
               check("B", {16'd0, bus.B}, {16'd0, e.b});
               check("Imm", {16'd0, bus.Imm}, {16'd0, e.imm});
               check("Rd", {29'd0, bus.Rd}, {29'd0, e.rd});
               check("Opcode", {27'd0, bus.Opcode}, {27'd0, e.opc});
            end
         end
         prev_v = bus.DecValid;
      end
   end

   initial begin
      bus.IRIn = '0; bus.IRValid = 1'b0; bus.DecAck = 1'b0;
      bus.RegWrite = 1'b0; bus.WriteAddr = '0; bus.WriteData = '0;
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;

      // Reset state
      RST = 1'b1;
      tick(); tick();
      RST = 1'b0;
      check("rst_decvalid", {31'd0, bus.DecValid}, 32'd0);
      check("rst_busy", {31'd0, bus.Busy}, 32'd0);
      check("rst_A", {16'd0, bus.A}, 32'd0);
      check("rst_Imm", {16'd0, bus.Imm}, 32'd0);
      check("rst_Rd_Opc", {24'd0, bus.Rd, bus.Opcode}, 32'd0);

      // R-type operand read
      wr(3'd3, 16'h1234);
      wr(3'd5, 16'hABCD);
      issue(16'b00_101_011_010_00001, 1'b0, 1'b0, 3'd0, 16'h0);
      check("r_A_const", {16'd0, bus.A}, 32'h1234);
      check("r_B_const", {16'd0, bus.B}, 32'hABCD);
      ack();

      // Immediate classes
      issue({5'b10110, 3'd1, 3'd2, 5'b01000}, 1'b0, 1'b0, 3'd0, 16'h0);
      check("imm_i_neg", {16'd0, bus.Imm}, 32'hFFF6);
      ack();
      issue({5'b01010, 3'd1, 3'd2, 5'b01001}, 1'b0, 1'b0, 3'd0, 16'h0);
      check("imm_i_pos", {16'd0, bus.Imm}, 32'h000A);
      ack();
      issue({11'h7FF, 5'b10000}, 1'b0, 1'b0, 3'd0, 16'h0);
      check("imm_j", {16'd0, bus.Imm}, 32'hFFFF);
      ack();
      issue({8'h80, 3'd0, 5'b11000}, 1'b0, 1'b0, 3'd0, 16'h0);
      check("imm_u", {16'd0, bus.Imm}, 32'h0080);
      ack();

      // Register 0 is hardwired
      wr(3'd0, 16'hFFFF);
      issue({2'b00, 3'd0, 3'd0, 3'd1, 5'd2}, 1'b0, 1'b0, 3'd0, 16'h0);
      check("x0_A", {16'd0, bus.A}, 32'h0);
      ack();

      // Writeback bypass in DECODE, then an ignored word while stalled
      issue({2'b00, 3'd3, 3'd4, 3'd6, 5'd4}, 1'b0, 1'b1, 3'd4, 16'h5A5A);
      check("bypass_A", {16'd0, bus.A}, 32'h5A5A);
      bus.IRIn = 16'hFFFF; bus.IRValid = 1'b1;
      #1;
      check("busy_stall", {31'd0, bus.Busy}, 32'd1);
      tick();
      bus.IRValid = 1'b0;
      check("stall_valid", {31'd0, bus.DecValid}, 32'd1);
      check("stall_A", {16'd0, bus.A}, 32'h5A5A);
      check("stall_opc_rd", {24'd0, bus.Rd, bus.Opcode}, {24'd0, 3'd6, 5'd4});
      tick();
      check("stall_valid2", {31'd0, bus.DecValid}, 32'd1);
      check("stall_opc2", {27'd0, bus.Opcode}, 32'd4);

      // Back-to-back: ack and new word together in VALID
      issue({2'b01, 3'd5, 3'd3, 3'd7, 5'd9}, 1'b1, 1'b0, 3'd0, 16'h0);
      issue({2'b00, 3'd4, 3'd5, 3'd1, 5'd3}, 1'b1, 1'b1, 3'd5, 16'h0F0F);
      ack();

      // Reset while in DECODE, with a writeback that must be dropped
      bus.IRIn = {2'b00, 3'd6, 3'd3, 3'd2, 5'd1}; bus.IRValid = 1'b1;
      tick();
      bus.IRValid = 1'b0;
      RST = 1'b1;
      bus.RegWrite = 1'b1; bus.WriteAddr = 3'd6; bus.WriteData = 16'h7777;
      tick();
      RST = 1'b0; bus.RegWrite = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      check("midrst_valid", {31'd0, bus.DecValid}, 32'd0);
      check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
      check("midrst_A", {16'd0, bus.A}, 32'd0);
      tick();
      check("midrst_stays_idle", {31'd0, bus.DecValid}, 32'd0);
      issue({2'b00, 3'd5, 3'd3, 3'd2, 5'd1}, 1'b0, 1'b0, 3'd0, 16'h0);
      ack();
      issue({2'b00, 3'd4, 3'd6, 3'd2, 5'd1}, 1'b0, 1'b0, 3'd0, 16'h0);
      check("rst_cycle_write_dropped", {16'd0, bus.A}, 32'd0);
      ack();

      tick(); tick(); tick();
      check("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
